// File: rtl/marcador_bcd.sv
// marcador_bcd: debounced push-button score counter 00..99 with registered active-low 7-seg digits; `BLANK_LEADING_ZERO_EN blanks a zero tens digit.
// Latency: Score moves DEBOUNCE_CYCLES+2 edges after Button rises, segments one edge later; no backpressure, Clear wins over a coincident press.
module marcador_bcd #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Button,
   input  logic       Clear,
   output logic [6:0] display0,
   output logic [6:0] display2,
   output logic [7:0] Score,
   output logic       Overflow
);

   localparam logic [17:0] CNT_LAST = 18'(DEBOUNCE_CYCLES - 1);

   logic        sync1;
   logic        sync2;
   logic        stable;
   logic [17:0] cnt;
   logic [3:0]  units;
   logic [3:0]  tens;
   logic        press;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b0000001;
         4'd1:    seg7 = 7'b1001111;
         4'd2:    seg7 = 7'b0010010;
         4'd3:    seg7 = 7'b0000110;
         4'd4:    seg7 = 7'b1001100;
         4'd5:    seg7 = 7'b0100100;
         4'd6:    seg7 = 7'b0100000;
         4'd7:    seg7 = 7'b0001111;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0000100;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= Button;
         sync2 <= sync1;
      end
   end

   // Any return of sync2 to the accepted level restarts the persistence count.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         stable <= 1'b0;
         cnt    <= '0;
      end else if (sync2 == stable) begin
         cnt    <= '0;
      end else if (cnt == CNT_LAST) begin
         stable <= sync2;
         cnt    <= '0;
      end else begin
         cnt    <= cnt + 18'd1;
      end
   end

   // Increment on the same edge that accepts a low-to-high change.
   assign press = sync2 & ~stable & (cnt == CNT_LAST);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         units    <= 4'd0;
         tens     <= 4'd0;
         Overflow <= 1'b0;
      end else if (Clear) begin
         units    <= 4'd0;
         tens     <= 4'd0;
         Overflow <= 1'b0;
      end else begin
         Overflow <= 1'b0;
         if (press) begin
            if (units == 4'd9) begin
               units <= 4'd0;
               if (tens == 4'd9) begin
                  tens     <= 4'd0;
                  Overflow <= 1'b1;
               end else begin
                  tens <= tens + 4'd1;
               end
            end else begin
               units <= units + 4'd1;
            end
         end
      end
   end

   assign Score = {tens, units};

   always_ff @(posedge Clock) begin
      if (Reset) begin
         display0 <= 7'b0000001;
`ifdef BLANK_LEADING_ZERO_EN
         display2 <= 7'b1111111;
`else
         display2 <= 7'b0000001;
`endif
      end else begin
         display0 <= seg7(units);
`ifdef BLANK_LEADING_ZERO_EN
         display2 <= (tens == 4'd0) ? 7'b1111111 : seg7(tens);
`else
         display2 <= seg7(tens);
`endif
      end
   end

endmodule

// File: tb/tb_marcador_bcd.sv
// Testbench for marcador_bcd with a short debounce window and a sample-window reference model.
`timescale 1ns/1ps
module tb_marcador_bcd;

   localparam int D = 4;
`ifdef BLANK_LEADING_ZERO_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif
   localparam logic [6:0] SEG [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

   logic       Clock = 1'b0;
   logic       Reset;
   logic       Button;
   logic       Clear;
   logic [6:0] display0;
   logic [6:0] display2;
   logic [7:0] Score;
   logic       Overflow;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic       pipe[$];
   logic       win[$];
   logic       m_stable;
   int         m_score;
   logic       m_ovf;
   logic [6:0] m_d0;
   logic [6:0] m_d2;

   marcador_bcd #(.DEBOUNCE_CYCLES(D)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Button   (Button),
      .Clear    (Clear),
      .display0 (display0),
      .display2 (display2),
      .Score    (Score),
      .Overflow (Overflow)
   );

   always #5 Clock = ~Clock;

   function automatic logic [7:0] bcd(input int s);
      return 8'(((s / 10) << 4) | (s % 10));
   endfunction

   function automatic logic [6:0] tens_seg(input int s);
      if (BLANK && s < 10) return 7'b1111111;
      return SEG[s / 10];
   endfunction

   // Advance one clock edge, updating the model from the inputs seen at that edge.
   task automatic tick();
      logic used;
      logic acc_press;
      logic all_flip;
      @(posedge Clock);
      acc_press = 1'b0;
      if (Reset) begin
         pipe.delete();
         pipe.push_back(1'b0);
         pipe.push_back(1'b0);
         win.delete();
         m_stable = 1'b0;
         m_score  = 0;
         m_ovf    = 1'b0;
         m_d0     = SEG[0];
         m_d2     = tens_seg(0);
      end else begin
         used = pipe.pop_front();
         pipe.push_back(Button);
         win.push_back(used);
         if (win.size() > D) void'(win.pop_front());
         if (win.size() == D) begin
            all_flip = 1'b1;
            foreach (win[i]) if (win[i] == m_stable) all_flip = 1'b0;
            if (all_flip) begin
               m_stable  = ~m_stable;
               acc_press = m_stable;
            end
         end
         m_d0 = SEG[m_score % 10];
         m_d2 = tens_seg(m_score);
         if (Clear) begin
            m_score = 0;
            m_ovf   = 1'b0;
         end else begin
            m_ovf = acc_press && (m_score == 99);
            if (acc_press) m_score = (m_score + 1) % 100;
         end
      end
      #1;
   endtask

   task automatic press_clean();
      Button = 1'b1;
      repeat (D + 2) tick();
      Button = 1'b0;
      repeat (D + 2) tick();
   endtask

   task automatic test_reset();
      Reset = 1'b1; Button = 1'b0; Clear = 1'b0;
      tick(); tick();
      checks++;
      if (Score !== 8'h00) begin errors++; $display("FAIL reset_score got=%h exp=00", Score); end
      checks++;
      if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", Overflow); end
      checks++;
      if (display0 !== 7'b0000001) begin errors++; $display("FAIL reset_d0 got=%b exp=0000001", display0); end
      checks++;
      if (display2 !== (BLANK ? 7'b1111111 : 7'b0000001))
         begin errors++; $display("FAIL reset_d2 got=%b blank=%0d", display2, BLANK); end
      Reset = 1'b0;
   endtask

   task automatic test_clean_press();
      Button = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         tick();
         checks++;
         if (Score !== ((e >= D + 2) ? 8'h01 : 8'h00))
            begin errors++; $display("FAIL clean_score edge=%0d got=%h", e, Score); end
         checks++;
         if ({Score, Overflow, display0, display2} !== {bcd(m_score), m_ovf, m_d0, m_d2})
            begin errors++; $display("FAIL clean_model edge=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", e,
               Score, Overflow, display0, display2, bcd(m_score), m_ovf, m_d0, m_d2); end
         if (e == D + 2) begin
            checks++;
            if (display0 !== 7'b0000001) begin errors++; $display("FAIL clean_d0_lag got=%b exp=0000001", display0); end
         end
         if (e == D + 3) begin
            checks++;
            if (display0 !== 7'b1001111) begin errors++; $display("FAIL clean_d0 got=%b exp=1001111", display0); end
         end
      end
      Button = 1'b0;
      for (int e = 0; e < 2 * D; e++) begin
         tick();
         checks++;
         if (Score !== 8'h01) begin errors++; $display("FAIL clean_release got=%h exp=01", Score); end
      end
   endtask

   task automatic test_bounce();
      int base;
      base = m_score;
      Button = 1'b1; tick();
      Button = 1'b0; tick();
      Button = 1'b1; tick();
      Button = 1'b0; tick();
      Button = 1'b1;
      for (int t = 1; t <= 12; t++) begin
         tick();
         checks++;
         if (Score !== bcd(base + ((t >= D + 2) ? 1 : 0)))
            begin errors++; $display("FAIL bounce_score t=%0d got=%h", t, Score); end
         checks++;
         if ({Score, Overflow, display0, display2} !== {bcd(m_score), m_ovf, m_d0, m_d2})
            begin errors++; $display("FAIL bounce_model t=%0d got=%h/%b exp=%h/%b", t, Score, Overflow, bcd(m_score), m_ovf); end
      end
      Button = 1'b0;
      repeat (2 * D + 2) tick();
      checks++;
      if (Score !== bcd(base + 1)) begin errors++; $display("FAIL bounce_final got=%h exp=%h", Score, bcd(base + 1)); end
   endtask

   task automatic test_clear_collision();
      Reset = 1'b1; tick(); Reset = 1'b0;
      repeat (42) press_clean();
      checks++;
      if (Score !== 8'h42) begin errors++; $display("FAIL clear_pre got=%h exp=42", Score); end
      Button = 1'b1;
      repeat (D + 1) tick();
      checks++;
      if (display0 !== 7'b0010010) begin errors++; $display("FAIL clear_d0_pre got=%b exp=0010010", display0); end
      Clear = 1'b1;
      tick();
      Clear = 1'b0;
      checks++;
      if (Score !== 8'h00) begin errors++; $display("FAIL clear_score got=%h exp=00", Score); end
      tick();
      checks++;
      if (display0 !== 7'b0000001) begin errors++; $display("FAIL clear_d0 got=%b exp=0000001", display0); end
      checks++;
      if (display2 !== (BLANK ? 7'b1111111 : 7'b0000001))
         begin errors++; $display("FAIL clear_d2 got=%b blank=%0d", display2, BLANK); end
      for (int t = 0; t < 6; t++) begin
         tick();
         checks++;
         if ({Score, Overflow, display0, display2} !== {8'h00, 1'b0, m_d0, m_d2})
            begin errors++; $display("FAIL clear_hold got=%h/%b exp=00/0", Score, Overflow); end
      end
      Button = 1'b0;
      repeat (2 * D + 2) tick();
   endtask

   task automatic test_wrap();
      int         ovf_seen;
      bit         wrapped;
      bit         saw99;
      bit         saw10;
      logic [7:0] prev;
      int         hi;
      int         lo;
      ovf_seen = 0; wrapped = 0; saw99 = 0; saw10 = 0;
      Reset = 1'b1; tick(); Reset = 1'b0;
      prev = Score;
      for (int p = 0; p < 600 && !wrapped; p++) begin
         hi = $urandom_range(D + 3, 1);
         lo = $urandom_range(D + 3, D);
         Button = 1'b1;
         for (int c = 0; c < hi + lo; c++) begin
            if (c == hi) Button = 1'b0;
            tick();
            checks++;
            if ({Score, Overflow, display0, display2} !== {bcd(m_score), m_ovf, m_d0, m_d2})
               begin errors++; $display("FAIL wrap_model p=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", p,
                  Score, Overflow, display0, display2, bcd(m_score), m_ovf, m_d0, m_d2); end
            if (Overflow === 1'b1) ovf_seen++;
            if (prev === 8'h09 && Score === 8'h10) saw10 = 1'b1;
            if (Score === 8'h99) saw99 = 1'b1;
            if (m_ovf) wrapped = 1'b1;
            prev = Score;
         end
      end
      checks++;
      if (!wrapped) begin errors++; $display("FAIL wrap_timeout no wrap within press budget"); end
      checks++;
      if (ovf_seen != 1) begin errors++; $display("FAIL wrap_ovf_cycles got=%0d exp=1", ovf_seen); end
      checks++;
      if (!saw99) begin errors++; $display("FAIL wrap_99 got=0 exp=1"); end
      checks++;
      if (!saw10) begin errors++; $display("FAIL wrap_09_10 got=0 exp=1"); end
      repeat (D + 2) tick();
   endtask

   task automatic test_reset_midcount();
      Button = 1'b1;
      repeat (4) tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      checks++;
      if (Score !== 8'h00) begin errors++; $display("FAIL midreset_score got=%h exp=00", Score); end
      for (int e = 6; e <= 14; e++) begin
         tick();
         checks++;
         if (Score !== ((e >= 11) ? 8'h01 : 8'h00))
            begin errors++; $display("FAIL midreset_edge edge=%0d got=%h", e, Score); end
         checks++;
         if ({Score, Overflow, display0, display2} !== {bcd(m_score), m_ovf, m_d0, m_d2})
            begin errors++; $display("FAIL midreset_model edge=%0d got=%h exp=%h", e, Score, bcd(m_score)); end
      end
      Button = 1'b0;
      repeat (D + 2) tick();
   endtask

   initial begin
      Reset = 1'b1;
      Button = 1'b0;
      Clear = 1'b0;
      pipe.push_back(1'b0);
      pipe.push_back(1'b0);
      m_stable = 1'b0; m_score = 0; m_ovf = 1'b0; m_d0 = SEG[0]; m_d2 = tens_seg(0);
      test_reset();
      test_clean_press();
      test_bounce();
      test_clear_collision();
      test_wrap();
      test_reset_midcount();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
